rle_job_scheduler: RTL
======================

# rle_job_scheduler

Front-end controller for the `rle` compression engine. It accepts compression job descriptors (message address, message size, output address) from `NREQ` requesters and grants them round-robin. It sequences the engine's `start`/`done` protocol and rejects sizes the engine cannot complete. A watchdog recovers a hung job, and each result is returned to its owner through a valid/ready response channel.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..4.
- `MAX_SIZE`, default 255: largest accepted `message_size`. The engine's 8-bit byte counter limits this.
- `TIMEOUT`, default 4096: WAIT-state cycles allowed before abort.
- `IDW`, default `$clog2(NREQ)`: requester id width.

Ports:
- `clk` in 1: single clock.
- `nreset` in 1: reset. **Asynchronous, active-high**: asserted when 1.
- `req_valid` in NREQ: descriptor offered, one bit per requester.
- `req_ready` out NREQ: descriptor accepted when valid & ready.
- `req_msg_addr` in NREQ*32: per-requester message address, flattened, requester i at [32i+31:32i].
- `req_msg_size` in NREQ*32: per-requester message size in bytes, flattened.
- `req_rle_addr` in NREQ*32: per-requester output address, flattened.
- `rsp_valid` out NREQ: response pending for requester i.
- `rsp_ready` in NREQ: requester consumes its response.
- `rsp_size` out 32: compressed size in bytes; 0 on error.
- `rsp_status` out 2: 00 OK, 01 BADSIZE, 10 TIMEOUT.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_message_addr` out 32: descriptor to the engine.
- `eng_message_size` out 32: descriptor to the engine.
- `eng_rle_addr` out 32: descriptor to the engine.
- `eng_done` in 1: engine done, treated as a level signal.
- `eng_rle_size` in 32: engine result.
- `eng_reset` out 1: active-high soft reset request to the engine, OR-ed with system reset at top level.
- `busy` out 1: state ≠ IDLE.
- `grant_id` out IDW: owner of the current job.

## Operation
States: IDLE, CHECK, START, WAIT, RECOVER, RESP.

- **IDLE**
  - Round-robin winner over `req_valid`, searching upward from `rr_ptr` with wraparound.
  - `req_ready[winner]` = 1 combinationally; all other bits 0.
  - On handshake: latch the descriptor into `eng_*` registers, set `grant_id`, go to CHECK.
  - With no `req_valid`, stay in IDLE.
- **CHECK**
  - `message_size` == 0 or > `MAX_SIZE`: set status BADSIZE and size 0, go to RESP.
  - Otherwise go to START.
- **START**
  - `eng_start` = 1 for exactly this cycle, then go to WAIT with the watchdog cleared.
- **WAIT**
  - `eng_done` is ignored on the first WAIT cycle, because the engine's level-done from the prior job is still settling.
  - From the second cycle on, `eng_done` = 1: latch `eng_rle_size`, set status OK, go to RESP.
  - Watchdog increments every WAIT cycle. When it reaches `TIMEOUT`-1 without done, go to RECOVER.
  - Done and timeout in the same cycle: done wins.
- **RECOVER**
  - `eng_reset` = 1 for 2 cycles.
  - Then set status TIMEOUT and size 0, and go to RESP.
- **RESP**
  - `rsp_valid[grant_id]` = 1; `rsp_size`/`rsp_status` are held stable.
  - On `rsp_ready[grant_id]`: `rr_ptr` = (`grant_id`+1) mod `NREQ`, go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.

Requester rules:
- `req_valid` must stay high with a stable descriptor until `req_ready`.
- `req_ready` is only ever asserted in IDLE.
- A requester may offer its next job while its response is pending; that job is arbitrated in the next IDLE.

## Timing
- **Reset values:** state IDLE, `rr_ptr` 0, all outputs 0 (`eng_*` descriptors 0, `grant_id` 0, `rsp_*` 0, `eng_reset` 0).
- **Reset mid-job:** immediate return to IDLE, with `eng_start` and `rsp_valid` dropped. The engine is reset by the system reset directly.
- **Handshake at cycle 0:** CHECK at 1, `eng_start` at 2. Earliest done is accepted at cycle 4; `rsp_valid` is high in the cycle after done is sampled.
- **BADSIZE:** `rsp_valid` at cycle 2 after the handshake.
- **TIMEOUT:** `rsp_valid` at START+`TIMEOUT`+3.
- **Output stability:** `eng_*` descriptor outputs are registered and stable from CHECK through RESP.
- **Widths:** `rsp_status` and `rsp_size` are registered. The watchdog is `$clog2(TIMEOUT)` bits and saturates, with no wraparound.
- **Throughput:** at most one job in flight. There is no preemption.

## Structure
- Package `rle_ctrl_pkg` holds:
  - state enum `sched_state_t`;
  - status constants `RLE_OK`, `RLE_BADSIZE`, `RLE_TIMEOUT`;
  - struct `rle_desc_t` {msg_addr, msg_size, rle_addr}.
- Sub-module `rle_rr_arbiter`, parameterized by `NREQ`:
  - inputs: request vector, pointer;
  - outputs: one-hot grant and id;
  - purely combinational.

## Test plan
- **Single job:** requester 0, size 8, `eng_done` 3 cycles after start with `eng_rle_size` = 4 → one `eng_start` pulse; `rsp_valid[0]`, status 00, size 4.
- **Contention:** both requesters valid, 3 rounds → grants in order 0,1,0,1,0,1.
- **Size boundaries:** size 0 → BADSIZE, no `eng_start`. Size 256 → BADSIZE. Size 255 → started.
- **Timeout:** `TIMEOUT`=16, `eng_done` never rises → `eng_reset` high 2 cycles; status 10, size 0.
- **Backpressure and stale done:** `rsp_ready` low 5 cycles → response held stable, no new `req_ready`. `eng_done` left high from the prior job → ignored in the first WAIT cycle.
- **Reset mid-WAIT:** assert `nreset` during WAIT → all outputs 0 asynchronously. After release, IDLE accepts requester 0 first.

Source files
------------

// File: rtl/rle_job_scheduler_pkg.sv
// Shared types and constants for the rle compression-engine front end.
package rle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_RECOVER = 3'd4,
    S_RESP    = 3'd5
  } sched_state_t;

  localparam logic [1:0] RLE_OK      = 2'b00;
  localparam logic [1:0] RLE_BADSIZE = 2'b01;
  localparam logic [1:0] RLE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [31:0] msg_addr;
    logic [31:0] msg_size;
    logic [31:0] rle_addr;
  } rle_desc_t;

  // The engine's byte counter cannot handle an empty message either.
  function automatic logic size_ok(input logic [31:0] size, input logic [31:0] max_size);
    return (size != '0) && (size <= max_size);
  endfunction

endpackage

// File: rtl/rle_job_scheduler_if.sv
// Requester-side job descriptor and response channels, flattened per requester.
interface rle_job_scheduler_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_msg_addr;
  logic [NREQ*32-1:0] req_msg_size;
  logic [NREQ*32-1:0] req_rle_addr;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [31:0]        rsp_size;
  logic [1:0]         rsp_status;

  modport master (
    output req_valid, req_msg_addr, req_msg_size, req_rle_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_size, rsp_status
  );

  modport slave (
    input  req_valid, req_msg_addr, req_msg_size, req_rle_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_size, rsp_status
  );
endinterface

// File: rtl/rle_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping.
module rle_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);
  localparam int unsigned N = NREQ;

  logic           found;
  logic [IDW-1:0] sel;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    sel      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sel = IDW'((32'(ptr) + i) % N);
      if (!found && req[sel]) begin
        found       = 1'b1;
        grant[sel]  = 1'b1;
        grant_id    = sel;
      end
    end
  end
endmodule

// File: rtl/rle_job_scheduler.sv
// Job front end for the rle engine: arbitrates requesters, runs start/done,
// rejects bad sizes, recovers hung jobs and routes the result back to its owner.
module rle_job_scheduler
  import rle_ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int MAX_SIZE = 255,
  parameter int TIMEOUT  = 4096,
  parameter int IDW      = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                nreset,
  rle_job_scheduler_if.slave  req_if,
  output logic                eng_start,
  output logic [31:0]         eng_message_addr,
  output logic [31:0]         eng_message_size,
  output logic [31:0]         eng_rle_addr,
  input  logic                eng_done,
  input  logic [31:0]         eng_rle_size,
  output logic                eng_reset,
  output logic                busy,
  output logic [IDW-1:0]      grant_id
);
  localparam int             WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  sched_state_t    state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  rle_desc_t       desc_q, desc_d;
  logic [31:0]     rsp_size_q, rsp_size_d;
  logic [1:0]      rsp_status_q, rsp_status_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            rec_cnt_q, rec_cnt_d;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_id;
  rle_desc_t       req_desc;
  logic [NREQ-1:0] rsp_oh;

  rle_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req      (req_if.req_valid),
    .ptr      (rr_ptr_q),
    .grant    (arb_grant),
    .grant_id (arb_id)
  );

  always_comb begin
    req_desc = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        req_desc.msg_addr = req_if.req_msg_addr[32*i +: 32];
        req_desc.msg_size = req_if.req_msg_size[32*i +: 32];
        req_desc.rle_addr = req_if.req_rle_addr[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    desc_d       = desc_q;
    rsp_size_d   = rsp_size_q;
    rsp_status_d = rsp_status_q;
    wdog_d       = wdog_q;
    rec_cnt_d    = rec_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          desc_d     = req_desc;
          grant_id_d = arb_id;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!size_ok(desc_q.msg_size, 32'(MAX_SIZE))) begin
          rsp_status_d = RLE_BADSIZE;
          rsp_size_d   = '0;
          state_d      = S_RESP;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A zero watchdog marks the first WAIT cycle, where done may be stale.
        if ((wdog_q != '0) && eng_done) begin
          rsp_size_d   = eng_rle_size;
          rsp_status_d = RLE_OK;
          state_d      = S_RESP;
        end else if (wdog_q == WD_LAST) begin
          rec_cnt_d = 1'b0;
          state_d   = S_RECOVER;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RECOVER: begin
        if (rec_cnt_q) begin
          rsp_status_d = RLE_TIMEOUT;
          rsp_size_d   = '0;
          state_d      = S_RESP;
        end else begin
          rec_cnt_d = 1'b1;
        end
      end
      S_RESP: begin
        if (req_if.rsp_ready[grant_id_q]) begin
          rr_ptr_d = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      desc_q       <= '0;
      rsp_size_q   <= '0;
      rsp_status_q <= '0;
      wdog_q       <= '0;
      rec_cnt_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      desc_q       <= desc_d;
      rsp_size_q   <= rsp_size_d;
      rsp_status_q <= rsp_status_d;
      wdog_q       <= wdog_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  always_comb begin
    rsp_oh = '0;
    if (state_q == S_RESP) rsp_oh[grant_id_q] = 1'b1;
  end

  assign req_if.req_ready  = (state_q == S_IDLE) ? arb_grant : '0;
  assign req_if.rsp_valid  = rsp_oh;
  assign req_if.rsp_size   = rsp_size_q;
  assign req_if.rsp_status = rsp_status_q;

  assign eng_start        = (state_q == S_START);
  assign eng_reset        = (state_q == S_RECOVER);
  assign busy             = (state_q != S_IDLE);
  assign grant_id         = grant_id_q;
  assign eng_message_addr = desc_q.msg_addr;
  assign eng_message_size = desc_q.msg_size;
  assign eng_rle_addr     = desc_q.rle_addr;
endmodule
